wdc_256i_16o_unpack: RTL
========================

Name: wdc_256i_16o_unpack

Overview:
- Single-clock width down-converter on the video read path.
- Takes 256-bit words, e.g. bursts read back from DDR into the read-side FIFO, and emits them as sixteen 16-bit pixels in order.
- Reverses the 16-to-256 packing done on the write path: the first pixel written lands in bits [15:0] and is emitted first.
- Two-entry internal buffer (shift stage + hold stage) sustains one pixel per clock with no bubble between wide words.

Parameters:
- IN_WIDTH, 256, wide input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, narrow output word width.
- RATIO, IN_WIDTH/OUT_WIDTH (16), slices per wide word; derived localparam, not overridable.
- CNT_WIDTH, 5, slice index width; must satisfy 2^CNT_WIDTH >= RATIO.

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept a wide word this cycle.
- in_data, input, IN_WIDTH, wide word; slice k = bits [k*OUT_WIDTH +: OUT_WIDTH].
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data this cycle.
- out_data, output, OUT_WIDTH, current narrow slice.
- out_last, output, 1, out_data is slice RATIO-1 of its wide word.
- level, output, CNT_WIDTH+2, narrow words currently held, range 0..2*RATIO.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - in_valid/in_data must be held until accepted.
- Storage: shift register sh_data with sh_valid and slice index idx (0..RATIO-1); hold register hd_data with hd_valid.
- out_valid = sh_valid; out_data = sh_data[idx slice]; out_last = sh_valid && (idx == RATIO-1).
- in_ready = !hd_valid. Registered state only; no combinational path from out_ready to in_ready.
- States, encoded by {sh_valid, hd_valid}:
  - EMPTY (0,0): an accept loads sh_data, sets idx=0 and sh_valid. out_valid rises the next cycle, so input-to-output latency is 1 clock.
  - ONE (1,0): an accept loads hd_data. On an output transfer with idx<RATIO-1, idx increments. On an output transfer of the last slice, sh_valid clears, unless an accept happens in the same cycle; in that case the new word loads directly into sh with idx=0 and hd stays empty.
  - FULL (1,1): in_ready=0. On transfer of the last slice, hd moves into sh with idx=0 and hd_valid clears. This gives a back-to-back boundary with no idle cycle.
- Simultaneous events:
  - ONE with the last slice transferred and an input accepted in the same cycle: go to ONE with the new word, idx=0.
  - ONE with a non-last slice transferred and an input accepted: go to FULL.
- Stalls: while out_ready=0, out_data and out_last stay stable and idx does not change.
- level arithmetic:
  - level = (sh_valid ? RATIO-idx : 0) + (hd_valid ? RATIO : 0), computed registered-consistent each cycle.
  - Never exceeds 2*RATIO = 32.
- Reset, applied at any time including mid-word:
  - sh_valid, hd_valid, idx cleared; any partially emitted word is discarded.
  - Outputs the cycle after reset is sampled: out_valid=0, out_last=0, in_ready=1, level=0, out_data=0.
  - sh_data and hd_data are cleared to 0.
- No overflow is possible: writes are blocked by in_ready. No underflow is possible: reads are gated by out_valid.

Test Plan:
- Single word: after reset, send in_data whose slice k = 16'hA000+k; out_ready=1. Required: out_valid from the cycle after accept; 16 consecutive outputs A000..A00F; out_last only on A00F; level goes 16→15→…→1→0.
- Back-to-back streaming: 4 words offered continuously, out_ready=1. Required: 64 outputs with no gap; in_ready low only while FULL; out_last pulses every 16th output.
- Backpressure: load 2 words with out_ready=0. Required: in_ready=0, level=32, third word not accepted, out_data frozen at word0 slice0. Then release: all 32 slices in order, in_ready rises the cycle after word1 moves from hold to shift.
- Random stall: out_ready toggled pseudo-randomly, in_valid random over 200 words. Required: the scoreboard sequence equals the input slices in LSB-first order; no drops or duplicates; level always matches the model.
- Reset mid-word: rst asserted after slice 5 of a word, with a second word in hold. Required: next cycle out_valid=0, level=0, in_ready=1. A new word afterwards starts at its slice 0.
- Edge concurrency: in ONE state, last slice consumed in the same cycle a new word is accepted. Required: next cycle out_data = new word slice 0, hd_valid=0, level=16.

Source files
------------

// File: rtl/wdc_256i_16o_unpack_if.sv
// Stream bundle for the 256-to-16 read-path unpacker: wide input side,
// narrow output side and the occupancy level.
interface wdc_256i_16o_unpack_if #(
   parameter int IN_WIDTH  = 256,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic [CNT_WIDTH+1:0] level;

   // Environment side: produces wide words, consumes pixels.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, level
   );

   // Unpacker side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, level
   );
endinterface

// File: rtl/wdc_256i_16o_unpack.sv
// Width down-converter: splits each wide word into RATIO narrow slices,
// slice 0 (LSBs) first, using a shift stage plus a one-word hold stage.
module wdc_256i_16o_unpack #(
   parameter int IN_WIDTH  = 256,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 5
) (
   input logic                  clk,
   input logic                  rst,
   wdc_256i_16o_unpack_if.slave bus
);
   localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
   localparam int LVL_WIDTH = CNT_WIDTH + 2;

   // State encoding is {sh_valid, hd_valid}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [IN_WIDTH-1:0]  sh_data;
   logic [IN_WIDTH-1:0]  hd_data;
   logic [CNT_WIDTH-1:0] idx;
   logic                 sh_valid;
   logic                 hd_valid;
   logic                 at_last;
   logic                 in_fire;
   logic                 out_fire;
   logic                 load_sh_in;
   logic                 load_sh_hd;
   logic                 load_hd;
   logic                 idx_step;

   assign sh_valid = state_q[1];
   assign hd_valid = state_q[0];
   assign at_last  = (idx == CNT_WIDTH'(RATIO - 1));
   // in_ready depends on registered state only, never on out_ready.
   assign in_fire  = bus.in_valid && !hd_valid;
   assign out_fire = sh_valid && bus.out_ready;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (in_fire) state_d = ONE;
         ONE: begin
            if (out_fire && at_last) state_d = in_fire ? ONE : EMPTY;
            else if (in_fire)        state_d = FULL;
         end
         FULL:    if (out_fire && at_last) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      load_sh_in    = 1'b0;
      load_sh_hd    = 1'b0;
      load_hd       = 1'b0;
      idx_step      = 1'b0;
      bus.out_data  = '0;
      bus.in_ready  = !hd_valid;
      bus.out_valid = sh_valid;
      bus.out_last  = sh_valid && at_last;
      bus.level     = (sh_valid ? LVL_WIDTH'(RATIO) - LVL_WIDTH'(idx) : '0)
                    + (hd_valid ? LVL_WIDTH'(RATIO) : '0);

      // A new word bypasses the hold stage when the shift stage frees up.
      load_sh_in = in_fire && (!sh_valid || (out_fire && at_last));
      load_hd    = in_fire && sh_valid && !(out_fire && at_last);
      load_sh_hd = hd_valid && out_fire && at_last;
      idx_step   = out_fire && !at_last;

      for (int k = 0; k < RATIO; k++) begin
         if (idx == CNT_WIDTH'(k)) bus.out_data = sh_data[k*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   // NOTE: data registers are reset too, so out_data reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_data <= '0;
         hd_data <= '0;
         idx     <= '0;
      end else begin
         if (load_sh_in) begin
            sh_data <= bus.in_data;
            idx     <= '0;
         end else if (load_sh_hd) begin
            sh_data <= hd_data;
            idx     <= '0;
         end else if (idx_step) begin
            idx <= idx + CNT_WIDTH'(1);
         end
         if (load_hd) hd_data <= bus.in_data;
      end
   end
endmodule
